obstacle_field: RTL and testbench

- Multi-slot obstacle engine for the runner game; replaces the single-tree model with NUM_SLOTS concurrent obstacles.
- Spawns obstacles with random type and random gap, scrolls them left at a speed that ramps up over time, and retires them off the left edge.
- Latches a sticky collision against the player bounding box and counts obstacles passed.
- Sits between the game FSM, the random generator and the pixel compositor; runs on the system clock, with motion gated by a frame tick.

---
 rtl/obstacle_pkg.sv | 34 +++
 rtl/obstacle_slot.sv | 92 +++++++++
 rtl/obstacle_field.sv | 152 +++++++++++++++
 tb/tb_obstacle_field.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_pkg.sv
// Shared definitions for the obstacle engine: type codes, per-type geometry and field widths.
package obstacle_pkg;

    typedef enum logic [1:0] {
        ObsSmall = 2'd0,
        ObsTall  = 2'd1,
        ObsWide  = 2'd2
    } obs_type_e;

    localparam int unsigned TYPE_W = 2;
    localparam int unsigned DIM_W  = 6;

    function automatic logic [DIM_W-1:0] obs_width(input logic [TYPE_W-1:0] t);
        case (obs_type_e'(t))
            ObsTall: return 6'd25;
            ObsWide: return 6'd51;
            default: return 6'd17;
        endcase
    endfunction

    function automatic logic [DIM_W-1:0] obs_height(input logic [TYPE_W-1:0] t);
        case (obs_type_e'(t))
            ObsTall: return 6'd50;
            ObsWide: return 6'd50;
            default: return 6'd35;
        endcase
    endfunction

    // Code 3 is unused; fold it onto the small obstacle.
    function automatic logic [TYPE_W-1:0] rand_to_type(input logic [1:0] r);
        return (r == 2'd3) ? 2'd0 : r;
    endfunction

endpackage

// File: rtl/obstacle_slot.sv
// One obstacle slot: position/type registers, scroll/retire on move strobe, player overlap test.
module obstacle_slot
    import obstacle_pkg::*;
#(
    parameter int unsigned X_W        = 11,
    parameter int unsigned LEFT_PAD   = 64,
    parameter int unsigned SPAWN_X    = 640,
    parameter int unsigned GROUND_Y   = 417,
    parameter int unsigned HIT_MARGIN = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              mv,
    input  logic [3:0]        speed,
    input  logic              spawn,
    input  logic [TYPE_W-1:0] spawn_type,
    input  logic [X_W+1:0]    px,
    input  logic [8:0]        player_y,
    input  logic [5:0]        player_w,
    input  logic [5:0]        player_h,
    output logic              valid,
    output logic [X_W-1:0]    xp,
    output logic [TYPE_W-1:0] typ,
    output logic              retire,
    output logic              hit
);

    localparam int unsigned CW = X_W + 2;
    localparam logic [X_W-1:0] SPAWN_XP = X_W'(SPAWN_X + LEFT_PAD);

    logic              valid_q, valid_d;
    logic [X_W-1:0]    xp_q, xp_d;
    logic [TYPE_W-1:0] type_q, type_d;

    always_comb begin
        valid_d = valid_q;
        xp_d    = xp_q;
        type_d  = type_q;
        retire  = 1'b0;
        if (mv) begin
            if (valid_q) begin
                if (xp_q <= X_W'(speed)) begin
                    valid_d = 1'b0;
                    retire  = 1'b1;
                end else begin
                    xp_d = xp_q - X_W'(speed);
                end
            end else if (spawn) begin
                valid_d = 1'b1;
                xp_d    = SPAWN_XP;
                type_d  = spawn_type;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            xp_q    <= '0;
            type_q  <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
            xp_q    <= '0;
            type_q  <= '0;
        end else begin
            valid_q <= valid_d;
            xp_q    <= xp_d;
            type_q  <= type_d;
        end
    end

    logic [CW-1:0] ow, oh, oy, p, py, pw, ph, m;

    assign ow = CW'(obs_width(type_q));
    assign oh = CW'(obs_height(type_q));
    assign oy = CW'(GROUND_Y) - oh;
    assign p  = CW'(xp_q);
    assign py = CW'(player_y);
    assign pw = CW'(player_w);
    assign ph = CW'(player_h);
    assign m  = CW'(HIT_MARGIN);

    // Each edge is pulled in by the margin so grazing contact is forgiven.
    assign hit = valid_q && (px + pw > p + m) && (p + ow > px + m) &&
                 (py + ph > oy + m) && (oy + oh > py + m);

    assign valid = valid_q;
    assign xp    = xp_q;
    assign typ   = type_q;

endmodule

// File: rtl/obstacle_field.sv
// Multi-slot obstacle engine: spawn allocator, gap counter, speed ramp and sticky collision.
module obstacle_field
    import obstacle_pkg::*;
#(
    parameter int unsigned NUM_SLOTS        = 3,
    parameter int unsigned X_W              = 11,
    parameter int unsigned LEFT_PAD         = 64,
    parameter int unsigned SPAWN_X          = 640,
    parameter int unsigned GROUND_Y         = 417,
    parameter int unsigned GAP_MIN          = 200,
    parameter logic [7:0]  GAP_RAND_MASK    = 8'hFF,
    parameter int unsigned SPEED_INIT       = 4,
    parameter int unsigned SPEED_MAX        = 12,
    parameter int unsigned SPEED_STEP_TICKS = 1000,
    parameter int unsigned HIT_MARGIN       = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick,
    input  logic                        run,
    input  logic                        clear,
    input  logic [7:0]                  rand_byte,
    input  logic [9:0]                  player_x,
    input  logic [8:0]                  player_y,
    input  logic [5:0]                  player_w,
    input  logic [5:0]                  player_h,
    output logic [NUM_SLOTS-1:0]        obj_valid,
    output logic [NUM_SLOTS*X_W-1:0]    obj_xp,
    output logic [NUM_SLOTS*TYPE_W-1:0] obj_type,
    output logic [3:0]                  speed,
    output logic                        collide,
    output logic [15:0]                 passed_count
);

    localparam int unsigned CW     = X_W + 2;
    localparam int unsigned GAP_W  = $clog2(GAP_MIN + 256);
    localparam int unsigned RAMP_W = $clog2(SPEED_STEP_TICKS + 1);

    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [RAMP_W-1:0]    ramp_q, ramp_d;
    logic [3:0]           speed_q, speed_d;
    logic [15:0]          passed_q, passed_d;
    logic                 collide_q;

    logic                 mv;
    logic                 spawn_due;
    logic                 found;
    logic [NUM_SLOTS-1:0] spawn_sel;
    logic [NUM_SLOTS-1:0] slot_retire;
    logic [NUM_SLOTS-1:0] slot_hit;
    logic [TYPE_W-1:0]    new_type;
    logic [CW-1:0]        px;

    assign mv        = tick & run & ~collide_q;
    assign spawn_due = (gap_q <= GAP_W'(speed_q));
    assign new_type  = rand_to_type(rand_byte[1:0]);
    assign px        = CW'(player_x) + CW'(LEFT_PAD);

    // Allocation looks only at pre-tick occupancy, so a slot retiring now stays empty this tick.
    always_comb begin
        spawn_sel = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!obj_valid[i] && !found) begin
                spawn_sel[i] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        obstacle_slot #(
            .X_W        (X_W),
            .LEFT_PAD   (LEFT_PAD),
            .SPAWN_X    (SPAWN_X),
            .GROUND_Y   (GROUND_Y),
            .HIT_MARGIN (HIT_MARGIN)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .clear      (clear),
            .mv         (mv),
            .speed      (speed_q),
            .spawn      (spawn_due & spawn_sel[i]),
            .spawn_type (new_type),
            .px         (px),
            .player_y   (player_y),
            .player_w   (player_w),
            .player_h   (player_h),
            .valid      (obj_valid[i]),
            .xp         (obj_xp[i*X_W +: X_W]),
            .typ        (obj_type[i*TYPE_W +: TYPE_W]),
            .retire     (slot_retire[i]),
            .hit        (slot_hit[i])
        );
    end

    always_comb begin
        gap_d    = gap_q;
        ramp_d   = ramp_q;
        speed_d  = speed_q;
        passed_d = passed_q;
        if (mv) begin
            // With every slot busy the gap parks at zero so the spawn retries each tick.
            if (spawn_due) begin
                gap_d = found ? GAP_W'(GAP_MIN) + GAP_W'(rand_byte & GAP_RAND_MASK) : '0;
            end else begin
                gap_d = gap_q - GAP_W'(speed_q);
            end
            if (ramp_q == RAMP_W'(SPEED_STEP_TICKS - 1)) begin
                ramp_d = '0;
                if (speed_q < 4'(SPEED_MAX)) begin
                    speed_d = speed_q + 4'd1;
                end
            end else begin
                ramp_d = ramp_q + 1'b1;
            end
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (slot_retire[i] && passed_d != 16'hFFFF) begin
                    passed_d = passed_d + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_q     <= GAP_W'(GAP_MIN);
            ramp_q    <= '0;
            speed_q   <= 4'(SPEED_INIT);
            passed_q  <= '0;
            collide_q <= 1'b0;
        end else if (clear) begin
            gap_q     <= GAP_W'(GAP_MIN);
            ramp_q    <= '0;
            speed_q   <= 4'(SPEED_INIT);
            passed_q  <= '0;
            collide_q <= 1'b0;
        end else begin
            gap_q     <= gap_d;
            ramp_q    <= ramp_d;
            speed_q   <= speed_d;
            passed_q  <= passed_d;
            collide_q <= collide_q | (|slot_hit);
        end
    end

    assign speed        = speed_q;
    assign collide      = collide_q;
    assign passed_count = passed_q;

endmodule

// File: tb/tb_obstacle_field.sv
// Bench for obstacle_field: three parameterisations driven in lockstep against a behavioural model.
module tb_obstacle_field;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       run = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] rnd = 8'd0;
    logic [9:0] player_x = 10'd900;
    logic [8:0] player_y = 9'd0;
    logic [5:0] player_w = 6'd1;
    logic [5:0] player_h = 6'd1;

    logic [2:0]  v0, v1, v2;
    logic [32:0] xp0, xp1, xp2;
    logic [5:0]  ty0, ty1, ty2;
    logic [3:0]  sp0, sp1, sp2;
    logic        col0, col1, col2;
    logic [15:0] pc0, pc1, pc2;
    logic [62:0] d_snap [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    obstacle_field u_dut0 (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .clear(clear), .rand_byte(rnd),
        .player_x(player_x), .player_y(player_y), .player_w(player_w), .player_h(player_h),
        .obj_valid(v0), .obj_xp(xp0), .obj_type(ty0), .speed(sp0), .collide(col0),
        .passed_count(pc0)
    );

    obstacle_field #(.GAP_MIN(8), .GAP_RAND_MASK(8'h00)) u_dut1 (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .clear(clear), .rand_byte(rnd),
        .player_x(player_x), .player_y(player_y), .player_w(player_w), .player_h(player_h),
        .obj_valid(v1), .obj_xp(xp1), .obj_type(ty1), .speed(sp1), .collide(col1),
        .passed_count(pc1)
    );

    obstacle_field #(.SPEED_STEP_TICKS(10)) u_dut2 (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .clear(clear), .rand_byte(rnd),
        .player_x(player_x), .player_y(player_y), .player_w(player_w), .player_h(player_h),
        .obj_valid(v2), .obj_xp(xp2), .obj_type(ty2), .speed(sp2), .collide(col2),
        .passed_count(pc2)
    );

    assign d_snap[0] = {v0, xp0, ty0, sp0, col0, pc0};
    assign d_snap[1] = {v1, xp1, ty1, sp1, col1, pc1};
    assign d_snap[2] = {v2, xp2, ty2, sp2, col2, pc2};

    // Behavioural model, one entry per instance.
    int cfg_gap_min [3] = '{200, 8, 200};
    int cfg_mask    [3] = '{255, 0, 255};
    int cfg_step    [3] = '{1000, 1000, 10};

    bit m_valid [3][3];
    int m_p     [3][3];
    int m_t     [3][3];
    int m_speed [3];
    int m_gap   [3];
    int m_ramp  [3];
    int m_pass  [3];
    bit m_col   [3];

    localparam logic [62:0] RESET_SNAP = {3'b0, 33'd0, 6'd0, 4'd4, 1'b0, 16'd0};

    function automatic int type_w(int t);
        return (t == 1) ? 25 : (t == 2) ? 51 : 17;
    endfunction

    function automatic int type_h(int t);
        return (t == 0) ? 35 : 50;
    endfunction

    task automatic model_reset(int k);
        for (int s = 0; s < 3; s++) begin
            m_valid[k][s] = 1'b0;
            m_p[k][s] = 0;
            m_t[k][s] = 0;
        end
        m_speed[k] = 4;
        m_gap[k] = cfg_gap_min[k];
        m_ramp[k] = 0;
        m_pass[k] = 0;
        m_col[k] = 1'b0;
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            bit hit;
            bit placed;
            bit was_free [3];
            int px;
            int sp;
            hit = 1'b0;
            px = int'(player_x) + 64;
            for (int s = 0; s < 3; s++) begin
                if (m_valid[k][s]) begin
                    int w, h, oy;
                    w = type_w(m_t[k][s]);
                    h = type_h(m_t[k][s]);
                    oy = 417 - h;
                    if (px + int'(player_w) > m_p[k][s] + 5 && m_p[k][s] + w > px + 5 &&
                        int'(player_y) + int'(player_h) > oy + 5 &&
                        oy + h > int'(player_y) + 5)
                        hit = 1'b1;
                end
            end
            if (clear) begin
                model_reset(k);
            end else begin
                if (tick && run && !m_col[k]) begin
                    sp = m_speed[k];
                    for (int s = 0; s < 3; s++) begin
                        was_free[s] = !m_valid[k][s];
                        if (m_valid[k][s]) begin
                            if (m_p[k][s] <= sp) begin
                                m_valid[k][s] = 1'b0;
                                if (m_pass[k] < 65535) m_pass[k]++;
                            end else begin
                                m_p[k][s] -= sp;
                            end
                        end
                    end
                    if (m_gap[k] <= sp) begin
                        placed = 1'b0;
                        for (int s = 0; s < 3; s++) begin
                            if (was_free[s] && !placed) begin
                                placed = 1'b1;
                                m_valid[k][s] = 1'b1;
                                m_p[k][s] = 704;
                                m_t[k][s] = (int'(rnd) % 4 == 3) ? 0 : int'(rnd) % 4;
                            end
                        end
                        m_gap[k] = placed ? cfg_gap_min[k] + (int'(rnd) & cfg_mask[k]) : 0;
                    end else begin
                        m_gap[k] -= sp;
                    end
                    m_ramp[k]++;
                    if (m_ramp[k] == cfg_step[k]) begin
                        m_ramp[k] = 0;
                        if (m_speed[k] < 12) m_speed[k]++;
                    end
                end
                if (hit) m_col[k] = 1'b1;
            end
        end
    endtask

    function automatic logic [62:0] m_snap(int k);
        logic [2:0]  v;
        logic [32:0] x;
        logic [5:0]  t;
        for (int s = 0; s < 3; s++) begin
            v[s] = m_valid[k][s];
            x[s*11 +: 11] = 11'(m_p[k][s]);
            t[s*2 +: 2] = 2'(m_t[k][s]);
        end
        return {v, x, t, 4'(m_speed[k]), m_col[k], 16'(m_pass[k])};
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tick = 1'b0;
        clear = 1'b0;
        for (int k = 0; k < 3; k++) model_reset(k);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (d_snap[k] !== RESET_SNAP) begin
                errors++;
                $display("FAIL reset dut%0d: got %h want %h", k, d_snap[k], RESET_SNAP);
            end
        end
    endtask

    task automatic test_first_spawn();
        run = 1'b1;
        rnd = 8'd0;
        for (int n = 1; n <= 50; n++) begin
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (d_snap[k] !== m_snap(k)) begin
                    errors++;
                    $display("FAIL first_spawn dut%0d tick %0d: got %h want %h",
                             k, n, d_snap[k], m_snap(k));
                end
            end
            if (n == 49) begin
                checks++;
                if (v0 !== 3'b000) begin
                    errors++;
                    $display("FAIL early_spawn: obj_valid %b want 000", v0);
                end
            end
        end
        checks++;
        if (v0 !== 3'b001 || xp0[10:0] !== 11'd704 || ty0[1:0] !== 2'd0) begin
            errors++;
            $display("FAIL spawn50: valid %b xp %0d type %0d want 001 704 0",
                     v0, xp0[10:0], ty0[1:0]);
        end
    endtask

    task automatic test_scroll();
        repeat (10) begin
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (d_snap[k] !== m_snap(k)) begin
                    errors++;
                    $display("FAIL scroll dut%0d: got %h want %h", k, d_snap[k], m_snap(k));
                end
            end
        end
        checks++;
        if (xp0[10:0] !== 11'd664) begin
            errors++;
            $display("FAIL scroll_pos: xp %0d want 664", xp0[10:0]);
        end
    endtask

    task automatic test_retire();
        repeat (165) begin
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (d_snap[k] !== m_snap(k)) begin
                    errors++;
                    $display("FAIL retire dut%0d: got %h want %h", k, d_snap[k], m_snap(k));
                end
            end
        end
        checks++;
        if (v0[0] !== 1'b1 || xp0[10:0] !== 11'd4) begin
            errors++;
            $display("FAIL pre_retire: valid0 %b xp %0d want 1 4", v0[0], xp0[10:0]);
        end
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        checks++;
        if (v0[0] !== 1'b0 || pc0 !== 16'd1) begin
            errors++;
            $display("FAIL retire_slot0: valid0 %b passed %0d want 0 1", v0[0], pc0);
        end
    endtask

    task automatic test_full_slots();
        bit seen;
        do_reset();
        run = 1'b1;
        rnd = 8'd0;
        player_x = 10'd900;
        for (int n = 1; n <= 8; n++) begin
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (d_snap[k] !== m_snap(k)) begin
                    errors++;
                    $display("FAIL full_fill dut%0d: got %h want %h", k, d_snap[k], m_snap(k));
                end
            end
        end
        checks++;
        if (v1 !== 3'b111 || xp1[10:0] !== 11'd680 || xp1[32:22] !== 11'd696) begin
            errors++;
            $display("FAIL full_defer: valid %b xp0 %0d xp2 %0d want 111 680 696",
                     v1, xp1[10:0], xp1[32:22]);
        end
        seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (d_snap[k] !== m_snap(k)) begin
                    errors++;
                    $display("FAIL full_wait dut%0d: got %h want %h", k, d_snap[k], m_snap(k));
                end
            end
            if (v1[0] === 1'b0) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL full_retire_timeout: valid %b want slot0 retired", v1);
        end
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        checks++;
        if (v1[0] !== 1'b1 || xp1[10:0] !== 11'd704) begin
            errors++;
            $display("FAIL full_respawn: valid0 %b xp %0d want 1 704", v1[0], xp1[10:0]);
        end
    endtask

    task automatic test_collision();
        bit seen;
        do_reset();
        run = 1'b1;
        rnd = 8'd0;
        player_x = 10'd100;
        player_y = 9'd372;
        player_w = 6'd42;
        player_h = 6'd45;
        seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (d_snap[k] !== m_snap(k)) begin
                    errors++;
                    $display("FAIL coll_run dut%0d: got %h want %h", k, d_snap[k], m_snap(k));
                end
            end
            if (v0[0] === 1'b1 && xp0[10:0] === 11'd200) seen = 1'b1;
            if (!seen) cycle();
        end
        checks++;
        if (!seen || col0 !== 1'b0) begin
            errors++;
            $display("FAIL coll_overlap: reached %0d collide %b want 1 0", seen, col0);
        end
        cycle();
        checks++;
        if (col0 !== 1'b1) begin
            errors++;
            $display("FAIL coll_latch: collide %b want 1", col0);
        end
        repeat (5) begin
            tick = 1'b1;
            cycle();
            tick = 1'b0;
        end
        checks++;
        if (xp0[10:0] !== 11'd200 || col0 !== 1'b1 || d_snap[0] !== m_snap(0)) begin
            errors++;
            $display("FAIL coll_freeze: xp %0d collide %b want 200 1", xp0[10:0], col0);
        end
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (d_snap[k] !== RESET_SNAP) begin
                errors++;
                $display("FAIL coll_clear dut%0d: got %h want %h", k, d_snap[k], RESET_SNAP);
            end
        end
        player_x = 10'd900;
        player_y = 9'd0;
        player_w = 6'd1;
        player_h = 6'd1;
    endtask

    task automatic test_ramp_priority();
        do_reset();
        run = 1'b1;
        rnd = 8'd0;
        for (int n = 1; n <= 100; n++) begin
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (d_snap[k] !== m_snap(k)) begin
                    errors++;
                    $display("FAIL ramp dut%0d tick %0d: got %h want %h",
                             k, n, d_snap[k], m_snap(k));
                end
            end
            if (n == 79 || n == 80 || n == 100) begin
                checks++;
                if (sp2 !== ((n == 79) ? 4'd11 : 4'd12)) begin
                    errors++;
                    $display("FAIL ramp_speed tick %0d: speed %0d", n, sp2);
                end
            end
        end
        tick = 1'b1;
        clear = 1'b1;
        cycle();
        tick = 1'b0;
        clear = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (d_snap[k] !== RESET_SNAP) begin
                errors++;
                $display("FAIL clear_priority dut%0d: got %h want %h", k, d_snap[k], RESET_SNAP);
            end
        end
    endtask

    task automatic test_run_hold();
        run = 1'b0;
        tick = 1'b1;
        repeat (20) cycle();
        tick = 1'b0;
        checks++;
        if (v0 !== 3'b000 || sp2 !== 4'd4 || d_snap[2] !== m_snap(2)) begin
            errors++;
            $display("FAIL run_hold: valid %b speed %0d want 000 4", v0, sp2);
        end
        run = 1'b1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            tick = ($urandom_range(0, 2) == 0);
            run = ($urandom_range(0, 7) != 0);
            clear = ($urandom_range(0, 149) == 0);
            rnd = 8'($urandom);
            if ($urandom_range(0, 63) == 0) begin
                player_x = 10'($urandom);
                player_y = 9'($urandom_range(300, 420));
                player_w = 6'($urandom);
                player_h = 6'($urandom);
            end
            cycle();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (d_snap[k] !== m_snap(k)) begin
                    errors++;
                    $display("FAIL random dut%0d cycle %0d: got %h want %h",
                             k, n, d_snap[k], m_snap(k));
                end
            end
        end
        tick = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_scroll();
        test_retire();
        test_full_slots();
        test_collision();
        test_ramp_priority();
        test_run_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
